// File: rtl/barrel_shifter_pipe.sv
// Two-stage ARM barrel shifter: stage A decodes and does the byte-granular
// coarse shift, stage B the fine shift plus carry-out and output register.
module barrel_shifter_pipe #(
   parameter int DATA_W = 32,
   parameter int AMT_W  = 5
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              flush,
   input  logic              in_valid,
   output logic              in_ready,
   input  logic [DATA_W-1:0] in_data,
   input  logic [AMT_W-1:0]  in_shift_amt,
   input  logic [1:0]        in_shift_type,
   input  logic              in_imm_enc,
   input  logic              in_carry,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [DATA_W-1:0] out_data,
   output logic              out_carry
);

   localparam logic [1:0] T_LSL = 2'b00;
   localparam logic [1:0] T_LSR = 2'b01;
   localparam logic [1:0] T_ASR = 2'b10;
   localparam logic [1:0] T_ROR = 2'b11;

   typedef enum logic [1:0] {
      SP_NONE,
      SP_LSR32,
      SP_ASR32,
      SP_RRX
   } special_e;

   typedef struct packed {
      logic [DATA_W-1:0] coarse;
      logic [DATA_W-1:0] orig;
      logic [AMT_W-1:0]  amt;
      logic [1:0]        stype;
      special_e          special;
      logic              amt_zero;
      logic              cin;
   } stage_a_t;

   function automatic logic [DATA_W-1:0] shift_op(
      input logic [DATA_W-1:0] d,
      input logic [1:0]        t,
      input logic [AMT_W-1:0]  k
   );
      logic [2*DATA_W-1:0] w;
      w = '0;
      unique case (t)
         T_LSL: w = {{DATA_W{1'b0}}, d << k};
         T_LSR: w = {{DATA_W{1'b0}}, d >> k};
         T_ASR: w = {{DATA_W{1'b0}}, $unsigned($signed(d) >>> k)};
         T_ROR: w = {d, d} >> k;
      endcase
      return w[DATA_W-1:0];
   endfunction

   logic     a_valid;
   logic     b_valid;
   logic     b_free;
   stage_a_t a_q;
   stage_a_t a_d;

   logic [AMT_W-1:0]  coarse_amt;
   logic              zero_imm;

   assign b_free    = !b_valid || out_ready;
   assign in_ready  = !flush && (!a_valid || b_free);
   assign out_valid = b_valid;

   assign coarse_amt = {in_shift_amt[AMT_W-1:3], 3'b000};
   assign zero_imm   = (in_shift_amt == '0) && in_imm_enc;

   always_comb begin
      a_d          = '0;
      a_d.coarse   = shift_op(in_data, in_shift_type, coarse_amt);
      a_d.orig     = in_data;
      a_d.amt      = in_shift_amt;
      a_d.stype    = in_shift_type;
      a_d.amt_zero = (in_shift_amt == '0);
      a_d.cin      = in_carry;
      a_d.special  = SP_NONE;
      unique case (1'b1)
         !zero_imm:                           a_d.special = SP_NONE;
         zero_imm && in_shift_type == T_LSL: a_d.special = SP_NONE;
         zero_imm && in_shift_type == T_LSR: a_d.special = SP_LSR32;
         zero_imm && in_shift_type == T_ASR: a_d.special = SP_ASR32;
         zero_imm && in_shift_type == T_ROR: a_d.special = SP_RRX;
      endcase
   end

   logic [AMT_W-1:0]  fine_amt;
   logic [AMT_W-1:0]  lsl_idx;
   logic [AMT_W-1:0]  rsh_idx;
   logic [DATA_W-1:0] b_data;
   logic              b_carry;

   assign fine_amt = {{(AMT_W-3){1'b0}}, a_q.amt[2:0]};
   // LSL carry is d[DATA_W-n]; mod-2**AMT_W negation gives that index
   assign lsl_idx  = AMT_W'(0) - a_q.amt;
   assign rsh_idx  = a_q.amt - AMT_W'(1);

   always_comb begin
      b_data  = '0;
      b_carry = 1'b0;
      unique case (a_q.special)
         SP_LSR32: begin
            b_data  = '0;
            b_carry = a_q.orig[DATA_W-1];
         end
         SP_ASR32: begin
            b_data  = {DATA_W{a_q.orig[DATA_W-1]}};
            b_carry = a_q.orig[DATA_W-1];
         end
         SP_RRX: begin
            b_data  = {a_q.cin, a_q.orig[DATA_W-1:1]};
            b_carry = a_q.orig[0];
         end
         SP_NONE: begin
            b_data = shift_op(a_q.coarse, a_q.stype, fine_amt);
            unique case (1'b1)
               a_q.amt_zero:
                  b_carry = a_q.cin;
               !a_q.amt_zero && a_q.stype == T_LSL:
                  b_carry = a_q.orig[lsl_idx];
               !a_q.amt_zero && a_q.stype != T_LSL:
                  b_carry = a_q.orig[rsh_idx];
            endcase
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_valid   <= 1'b0;
         b_valid   <= 1'b0;
         a_q       <= '0;
         out_data  <= '0;
         out_carry <= 1'b0;
      end else if (flush) begin
         a_valid <= 1'b0;
         b_valid <= 1'b0;
      end else begin
         if (b_free) begin
            b_valid <= a_valid;
            if (a_valid) begin
               out_data  <= b_data;
               out_carry <= b_carry;
            end
         end
         if (in_ready) begin
            a_valid <= in_valid;
            if (in_valid) a_q <= a_d;
         end
      end
   end

endmodule

// File: tb/tb_barrel_shifter_pipe.sv
// Bench for barrel_shifter_pipe: spec-level shift model with a scoreboard,
// plus directed literal vectors for timing, stall, flush and reset.
module tb_barrel_shifter_pipe;

   logic        clk;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic [4:0]  in_shift_amt;
   logic [1:0]  in_shift_type;
   logic        in_imm_enc;
   logic        in_carry;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
   logic        out_carry;

   int checks   = 0;
   int failures = 0;

   logic [32:0] exp_q[$];

   barrel_shifter_pipe #(.DATA_W(32), .AMT_W(5)) dut (
      .clk          (clk),
      .rst_n        (rst_n),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_ready     (in_ready),
      .in_data      (in_data),
      .in_shift_amt (in_shift_amt),
      .in_shift_type(in_shift_type),
      .in_imm_enc   (in_imm_enc),
      .in_carry     (in_carry),
      .out_valid    (out_valid),
      .out_ready    (out_ready),
      .out_data     (out_data),
      .out_carry    (out_carry)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Returns {carry, result} straight from the ARM shifter rules.
   function automatic logic [32:0] model(
      input logic [31:0] d,
      input int          n,
      input logic [1:0]  t,
      input logic        imm,
      input logic        cin
   );
      logic [63:0] w;
      if (n == 0) begin
         if (imm && t == 2'd1) return {d[31], 32'h0};
         if (imm && t == 2'd2) return {d[31], {32{d[31]}}};
         if (imm && t == 2'd3) return {d[0], cin, d[31:1]};
         return {cin, d};
      end
      case (t)
         2'd0: begin
            w = {32'h0, d} << n;
            return {w[32], w[31:0]};
         end
         2'd1: return {d[n-1], d >> n};
         2'd2: begin
            w = {{32{d[31]}}, d} >> n;
            return {d[n-1], w[31:0]};
         end
         default: begin
            w = {d, d} >> n;
            return {d[n-1], w[31:0]};
         end
      endcase
   endfunction

   task automatic chk(input string name, input logic [63:0] act,
                      input logic [63:0] req);
      checks++;
      if (act !== req) begin
         failures++;
         $display("FAIL %s actual=%h required=%h", name, act, req);
      end
   endtask

   always @(negedge rst_n) exp_q.delete();

   always @(posedge clk) begin
      if (rst_n) begin
         if (flush) begin
            exp_q.delete();
         end else begin
            if (out_valid && out_ready && exp_q.size() > 0)
               void'(exp_q.pop_front());
            if (in_valid && in_ready)
               exp_q.push_back(model(in_data, int'(in_shift_amt),
                                     in_shift_type, in_imm_enc, in_carry));
         end
      end
   end

   always @(negedge clk) begin
      if (rst_n && out_valid) begin
         if (exp_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL sb_unexpected actual=%h required=none",
                     {out_carry, out_data});
         end else begin
            chk("sb_result", 64'({out_carry, out_data}), 64'(exp_q[0]));
         end
      end
   end

   task automatic set_req(input logic [31:0] d, input logic [4:0] n,
                          input logic [1:0] t, input logic imm,
                          input logic cin);
      in_data       = d;
      in_shift_amt  = n;
      in_shift_type = t;
      in_imm_enc    = imm;
      in_carry      = cin;
   endtask

   task automatic drain(input string name);
      out_ready = 1'b1;
      in_valid  = 1'b0;
      for (int i = 0; i < 40 && exp_q.size() != 0; i++) begin
         @(posedge clk);
         #2;
      end
      chk({name, "_drain"}, 64'(exp_q.size()), 64'(0));
   endtask

   // Entered at posedge+2 with an empty pipe and out_ready high.
   task automatic single(input string name, input logic [31:0] d,
                         input logic [4:0] n, input logic [1:0] t,
                         input logic imm, input logic cin,
                         input logic [31:0] ed, input logic ec);
      chk({name, "_model"}, 64'(model(d, int'(n), t, imm, cin)),
          64'({ec, ed}));
      in_valid = 1'b1;
      set_req(d, n, t, imm, cin);
      @(posedge clk);
      #2;
      in_valid = 1'b0;
      in_carry = ~cin;
      in_data  = ~d;
      @(negedge clk);
      chk({name, "_lat1"}, 64'(out_valid), 64'(0));
      @(negedge clk);
      chk({name, "_valid"}, 64'(out_valid), 64'(1));
      chk({name, "_data"}, 64'(out_data), 64'(ed));
      chk({name, "_carry"}, 64'(out_carry), 64'(ec));
      @(posedge clk);
      #2;
      drain(name);
   endtask

   logic [31:0] sd[4];
   logic [4:0]  sn[4];
   logic [1:0]  st[4];
   logic [31:0] se[4];
   logic        sc[4];

   task automatic drive_s(input int i);
      set_req(sd[i], sn[i], st[i], 1'b0, 1'b0);
   endtask

   initial begin
      logic acc;
      int   idx;
      int   k;

      sd = '{32'h8000_000F, 32'h1234_5678, 32'h0000_0003, 32'h8000_0010};
      sn = '{5'd4, 5'd8, 5'd1, 5'd4};
      st = '{2'd0, 2'd3, 2'd1, 2'd2};
      se = '{32'h0000_00F0, 32'h7812_3456, 32'h0000_0001, 32'hF800_0001};
      sc = '{1'b0, 1'b0, 1'b1, 1'b0};

      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      set_req(32'h0, 5'd0, 2'd0, 1'b0, 1'b0);
      repeat (2) @(posedge clk);
      #1;
      chk("rst_out_valid", 64'(out_valid), 64'(0));
      chk("rst_out_data", 64'(out_data), 64'(0));
      chk("rst_out_carry", 64'(out_carry), 64'(0));
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_in_ready", 64'(in_ready), 64'(1));
      chk("rst_idle", 64'(out_valid), 64'(0));
      @(posedge clk);
      #2;

      single("lsl4", 32'h8000_000F, 5'd4, 2'd0, 1'b0, 1'b0, 32'h0000_00F0, 1'b0);
      single("lsl1", 32'h8000_0000, 5'd1, 2'd0, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
      single("lsr32", 32'h8000_0001, 5'd0, 2'd1, 1'b1, 1'b0, 32'h0000_0000, 1'b1);
      single("lsr0", 32'h8000_0001, 5'd0, 2'd1, 1'b0, 1'b0, 32'h8000_0001, 1'b0);
      single("asr32", 32'h8000_0000, 5'd0, 2'd2, 1'b1, 1'b0, 32'hFFFF_FFFF, 1'b1);
      single("asr31", 32'h4000_0000, 5'd31, 2'd2, 1'b0, 1'b0, 32'h0000_0000, 1'b1);
      single("rrx", 32'h0000_0003, 5'd0, 2'd3, 1'b1, 1'b1, 32'h8000_0001, 1'b1);
      single("ror8", 32'h1234_5678, 5'd8, 2'd3, 1'b0, 1'b0, 32'h7812_3456, 1'b0);
      single("lsl0", 32'hDEAD_BEEF, 5'd0, 2'd0, 1'b1, 1'b1, 32'hDEAD_BEEF, 1'b1);
      single("lsr31", 32'h8000_0000, 5'd31, 2'd1, 1'b0, 1'b0, 32'h0000_0001, 1'b0);
      single("asr7", 32'h8000_0080, 5'd7, 2'd2, 1'b0, 1'b0, 32'hFF00_0001, 1'b0);
      single("ror1", 32'h0000_0001, 5'd1, 2'd3, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
      single("lsl31", 32'h0000_0003, 5'd31, 2'd0, 1'b0, 1'b0, 32'h8000_0000, 1'b1);
      single("ror0", 32'h0000_0005, 5'd0, 2'd3, 1'b0, 1'b0, 32'h0000_0005, 1'b0);

      // back-to-back with a three-cycle output stall
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_s(0);
      @(negedge clk);
      chk("stall_acc0", 64'(in_ready), 64'(1));
      @(posedge clk);
      #2;
      drive_s(1);
      @(negedge clk);
      chk("stall_acc1", 64'(in_ready), 64'(1));
      @(posedge clk);
      #2;
      drive_s(2);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("stall_in_ready", 64'(in_ready), 64'(0));
         chk("stall_valid", 64'(out_valid), 64'(1));
         chk("stall_hold", 64'({out_carry, out_data}), 64'({sc[0], se[0]}));
         @(posedge clk);
         #2;
      end
      out_ready = 1'b1;
      idx = 2;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rel_valid", 64'(out_valid), 64'(1));
         chk("rel_order", 64'({out_carry, out_data}), 64'({sc[i], se[i]}));
         acc = in_ready;
         @(posedge clk);
         #2;
         if (in_valid && acc) begin
            idx++;
            if (idx < 4) drive_s(idx);
            else in_valid = 1'b0;
         end
      end
      @(negedge clk);
      chk("rel_no_dup", 64'(out_valid), 64'(0));
      @(posedge clk);
      #2;
      drain("stall");

      // flush with both stages occupied
      out_ready = 1'b0;
      in_valid  = 1'b1;
      drive_s(0);
      @(posedge clk);
      #2;
      drive_s(1);
      @(posedge clk);
      #2;
      flush = 1'b1;
      drive_s(2);
      @(negedge clk);
      chk("flush_in_ready", 64'(in_ready), 64'(0));
      chk("flush_pre_valid", 64'(out_valid), 64'(1));
      @(posedge clk);
      #2;
      flush    = 1'b0;
      in_valid = 1'b0;
      @(negedge clk);
      chk("flush_valid", 64'(out_valid), 64'(0));
      out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("flush_empty", 64'(out_valid), 64'(0));
      end
      @(posedge clk);
      #2;

      // swept stream through the scoreboard with irregular back-pressure
      idx = 0;
      k   = 0;
      in_valid = 1'b1;
      while (idx < 256 && k < 3000) begin
         set_req(32'(32'h9E37_79B9 * (idx + 1)), 5'(idx % 32),
                 2'(idx / 64), 1'((idx / 32) % 2), 1'((idx >> 2) & 1));
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #2;
         k++;
         out_ready = (k % 7) != 3;
         if (acc) idx++;
      end
      in_valid = 1'b0;
      chk("stream_accepted", 64'(idx), 64'(256));
      drain("stream");

      // asynchronous reset in mid-stream
      out_ready = 1'b1;
      in_valid  = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive_s(i);
         @(posedge clk);
         #2;
      end
      drive_s(3);
      #1;
      chk("pre_rst_valid", 64'(out_valid), 64'(1));
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 64'(out_valid), 64'(0));
      chk("arst_data", 64'(out_data), 64'(0));
      chk("arst_carry", 64'(out_carry), 64'(0));
      in_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("post_rst_valid", 64'(out_valid), 64'(0));
      chk("post_rst_ready", 64'(in_ready), 64'(1));
      @(posedge clk);
      #2;
      single("recover", 32'h1234_5678, 5'd8, 2'd3, 1'b0, 1'b0, 32'h7812_3456, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
